// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
// Shares one data-memory read channel and one write channel among
// NUM_CONSUMERS per-thread load-store units. Grants are round-robin, one
// transfer in flight at a time, reads win over writes for the same consumer.
//
// Handshake semantics (both sides, both directions):
//   A requester raises valid with address/data and holds them while valid is
//   high. The responder answers with ready. Toward memory, the transfer
//   completes on the first rising edge where valid and ready are both 1.
//   Toward a consumer, ready stays high until that consumer's matching valid
//   is seen low. If the owner drops valid early, the granted transfer still
//   completes and ready is shown for one cycle.
//
// Every output comes straight from a flop. The next-state logic computes
// the next value of each output, and one register block stores it.
module mem_request_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready,
  output logic [2:0]                              state_debug
);

  localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [PTR_BITS-1:0] LAST_IDX = PTR_BITS'(NUM_CONSUMERS - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_t;

  state_t state, state_n;
  logic [PTR_BITS-1:0] owner, owner_n;
  logic [PTR_BITS-1:0] rr_ptr, rr_ptr_n;

  // Next values of the registered outputs
  logic                                    mem_read_valid_n;
  logic [ADDR_BITS-1:0]                    mem_read_address_n;
  logic                                    mem_write_valid_n;
  logic [ADDR_BITS-1:0]                    mem_write_address_n;
  logic [DATA_BITS-1:0]                    mem_write_data_n;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_n;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready_n;

  // Round-robin scan results
  logic                grant_found;
  logic                grant_read;
  logic [PTR_BITS-1:0] grant_idx;
  logic [PTR_BITS-1:0] scan_idx;
  logic [PTR_BITS-1:0] owner_next_ptr;

  assign state_debug    = state;
  assign owner_next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // Scan from rr_ptr, wrapping, and pick the first consumer with any request
  always_comb begin
    grant_found = 1'b0;
    grant_read  = 1'b0;
    grant_idx   = '0;
    scan_idx    = rr_ptr;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!grant_found &&
          (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
        grant_read  = consumer_read_valid[scan_idx];
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
  end

  // Next-state and next-output logic; every value holds unless a transition changes it
  always_comb begin
    state_n                = state;
    owner_n                = owner;
    rr_ptr_n               = rr_ptr;
    mem_read_valid_n       = mem_read_valid;
    mem_read_address_n     = mem_read_address;
    mem_write_valid_n      = mem_write_valid;
    mem_write_address_n    = mem_write_address;
    mem_write_data_n       = mem_write_data;
    consumer_read_ready_n  = consumer_read_ready;
    consumer_read_data_n   = consumer_read_data;
    consumer_write_ready_n = consumer_write_ready;

    case (state)
      IDLE: begin
        if (grant_found) begin
          owner_n = grant_idx;
          if (grant_read) begin
            mem_read_valid_n   = 1'b1;
            mem_read_address_n = consumer_read_address[grant_idx];
            state_n            = READ_WAITING;
          end else begin
            mem_write_valid_n   = 1'b1;
            mem_write_address_n = consumer_write_address[grant_idx];
            mem_write_data_n    = consumer_write_data[grant_idx];
            state_n             = WRITE_WAITING;
          end
        end
      end

      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_read_valid_n             = 1'b0;
          consumer_read_ready_n[owner] = 1'b1;
          consumer_read_data_n[owner]  = mem_read_data;
          state_n                      = READ_RELAYING;
        end
      end

      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_write_valid_n             = 1'b0;
          consumer_write_ready_n[owner] = 1'b1;
          state_n                       = WRITE_RELAYING;
        end
      end

      READ_RELAYING: begin
        if (!consumer_read_valid[owner]) begin
          consumer_read_ready_n[owner] = 1'b0;
          rr_ptr_n                     = owner_next_ptr;
          state_n                      = IDLE;
        end
      end

      WRITE_RELAYING: begin
        if (!consumer_write_valid[owner]) begin
          consumer_write_ready_n[owner] = 1'b0;
          rr_ptr_n                      = owner_next_ptr;
          state_n                       = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, owner, pointer and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      owner                <= '0;
      rr_ptr               <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      state                <= state_n;
      owner                <= owner_n;
      rr_ptr               <= rr_ptr_n;
      mem_read_valid       <= mem_read_valid_n;
      mem_read_address     <= mem_read_address_n;
      mem_write_valid      <= mem_write_valid_n;
      mem_write_address    <= mem_write_address_n;
      mem_write_data       <= mem_write_data_n;
      consumer_read_ready  <= consumer_read_ready_n;
      consumer_read_data   <= consumer_read_data_n;
      consumer_write_ready <= consumer_write_ready_n;
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: batches of consumer requests, a reference
// model that orders each batch by round-robin and computes read data from a
// model memory, a memory responder with random latency, and a monitor that
// checks every memory request and consumer completion against the queue.
module tb_mem_request_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int EW = 1 + 3 + AW + DW;  // {is_write, consumer, addr, data}

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         consumer_read_valid;
  logic [N-1:0][AW-1:0] consumer_read_address;
  logic [N-1:0]         consumer_read_ready;
  logic [N-1:0][DW-1:0] consumer_read_data;
  logic [N-1:0]         consumer_write_valid;
  logic [N-1:0][AW-1:0] consumer_write_address;
  logic [N-1:0][DW-1:0] consumer_write_data;
  logic [N-1:0]         consumer_write_ready;
  logic                 mem_read_valid;
  logic [AW-1:0]        mem_read_address;
  logic                 mem_read_ready;
  logic [DW-1:0]        mem_read_data;
  logic                 mem_write_valid;
  logic [AW-1:0]        mem_write_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_ready;
  logic [2:0]           state_debug;

  mem_request_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready),
    .state_debug            (state_debug)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_rd_starts = 0;
  int n_wr_starts = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur;
  bit            cur_valid = 1'b0;

  logic [DW-1:0] ref_mem   [256];
  logic [DW-1:0] mem_store [256];
  logic [DW-1:0] last_rd   [N];
  int            model_rr = 0;
  int            fixed_lat = -1;
  int            rd_lat = -1;
  int            wr_lat = -1;

  // Current batch description
  bit            b_rv [N];
  bit            b_wv [N];
  logic [AW-1:0] b_ra [N];
  logic [AW-1:0] b_wa [N];
  logic [DW-1:0] b_wd [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input bit w, input int c,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [2:0] c3;
    c3 = 3'(c);
    return {w, c3, a, d};
  endfunction

  // ---------------- reference model ----------------
  // Orders a batch of simultaneous requests: repeatedly scan from the
  // pointer, serve the first pending consumer (read before write), and move
  // the pointer just past it. Reads see all earlier writes.
  task automatic model_batch();
    bit pr [N];
    bit pw [N];
    bit found;
    int i;
    for (int k = 0; k < N; k++) begin
      pr[k] = b_rv[k];
      pw[k] = b_wv[k];
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (model_rr + k) % N;
        if (pr[i]) begin
          exp_q.push_back(pack(1'b0, i, b_ra[i], ref_mem[b_ra[i]]));
          last_rd[i] = ref_mem[b_ra[i]];
          pr[i] = 1'b0;
          found = 1'b1;
        end else if (pw[i]) begin
          exp_q.push_back(pack(1'b1, i, b_wa[i], b_wd[i]));
          ref_mem[b_wa[i]] = b_wd[i];
          pw[i] = 1'b0;
          found = 1'b1;
        end
        if (found) begin
          model_rr = (i + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic clear_batch();
    for (int k = 0; k < N; k++) begin
      b_rv[k] = 1'b0;
      b_wv[k] = 1'b0;
      b_ra[k] = '0;
      b_wa[k] = '0;
      b_wd[k] = '0;
    end
  endtask

  task automatic drive_batch();
    for (int k = 0; k < N; k++) begin
      consumer_read_valid[k]    = b_rv[k];
      consumer_read_address[k]  = b_ra[k];
      consumer_write_valid[k]   = b_wv[k];
      consumer_write_address[k] = b_wa[k];
      consumer_write_data[k]    = b_wd[k];
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        rd_lat = -1;
        wr_lat = -1;
      end else begin
        if (mem_read_ready) begin
          mem_read_ready = 1'b0;
          rd_lat = -1;
          mem_read_data = DW'($urandom);
        end else if (mem_read_valid) begin
          if (rd_lat < 0) rd_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          if (rd_lat == 0) begin
            mem_read_ready = 1'b1;
            mem_read_data  = mem_store[mem_read_address];
          end else begin
            rd_lat--;
            mem_read_data = DW'($urandom);
          end
        end else begin
          mem_read_data = DW'($urandom);
        end
        if (mem_write_ready) begin
          mem_write_ready = 1'b0;
          wr_lat = -1;
        end else if (mem_write_valid) begin
          if (wr_lat < 0) wr_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          if (wr_lat == 0) begin
            mem_write_ready = 1'b1;
            mem_store[mem_write_address] = mem_write_data;
          end else begin
            wr_lat--;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic mem_start(input bit w);
    if (w) n_wr_starts++; else n_rd_starts++;
    check("exp_q_nonempty_at_mem_request", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      cur_valid = 1'b1;
      check("mem_request_kind", 32'(w), 32'(cur[EW-1]));
      if (w) begin
        check("mem_write_address", 32'(mem_write_address), 32'(cur[AW+DW-1:DW]));
        check("mem_write_data", 32'(mem_write_data), 32'(cur[DW-1:0]));
      end else begin
        check("mem_read_address", 32'(mem_read_address), 32'(cur[AW+DW-1:DW]));
      end
    end
  endtask

  task automatic finish_xfer(input bit w, input int i);
    check("ready_has_granted_transfer", 32'(cur_valid), 32'd1);
    if (cur_valid) begin
      check("completion_kind", 32'(w), 32'(cur[EW-1]));
      check("completion_consumer", 32'(i), 32'(cur[EW-2 -: 3]));
      if (!w) check("consumer_read_data", 32'(consumer_read_data[i]), 32'(cur[DW-1:0]));
      cur_valid = 1'b0;
    end
  endtask

  initial begin
    bit            pmr;
    bit            pmw;
    logic [N-1:0]  prr;
    logic [N-1:0]  pwr;
    logic [AW-1:0] hold_ra;
    logic [AW-1:0] hold_wa;
    logic [DW-1:0] hold_wd;
    pmr = 1'b0; pmw = 1'b0; prr = '0; pwr = '0;
    hold_ra = '0; hold_wa = '0; hold_wd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pmr = 1'b0; pmw = 1'b0; prr = '0; pwr = '0;
      end else begin
        check("mem_valid_overlap", 32'(mem_read_valid & mem_write_valid), 32'd0);
        check("ready_onehot", 32'($countones({consumer_read_ready, consumer_write_ready}) > 1), 32'd0);
        if (mem_read_valid && pmr)
          check("mem_read_address_stable", 32'(mem_read_address), 32'(hold_ra));
        if (mem_write_valid && pmw) begin
          check("mem_write_address_stable", 32'(mem_write_address), 32'(hold_wa));
          check("mem_write_data_stable", 32'(mem_write_data), 32'(hold_wd));
        end
        if (mem_read_valid && !pmr) mem_start(1'b0);
        if (mem_write_valid && !pmw) mem_start(1'b1);
        for (int i = 0; i < N; i++) begin
          if (consumer_read_ready[i] && !prr[i]) finish_xfer(1'b0, i);
          if (consumer_write_ready[i] && !pwr[i]) finish_xfer(1'b1, i);
        end
        pmr = mem_read_valid;
        pmw = mem_write_valid;
        prr = consumer_read_ready;
        pwr = consumer_write_ready;
        hold_ra = mem_read_address;
        hold_wa = mem_write_address;
        hold_wd = mem_write_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue the current batch; each consumer drops valid 0..2 cycles after it
  // sees ready. Ends when everything has been served and released.
  task automatic run_batch(input string tag);
    int  rh [N];
    int  wh [N];
    bit  done;
    done = 1'b0;
    for (int k = 0; k < N; k++) begin
      rh[k] = -1;
      wh[k] = -1;
    end
    model_batch();
    @(posedge clk);
    #1;
    drive_batch();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (consumer_read_valid[i] && consumer_read_ready[i]) begin
          if (rh[i] < 0) rh[i] = int'($urandom_range(0, 2));
          if (rh[i] == 0) consumer_read_valid[i] = 1'b0; else rh[i]--;
        end
        if (consumer_write_valid[i] && consumer_write_ready[i]) begin
          if (wh[i] < 0) wh[i] = int'($urandom_range(0, 2));
          if (wh[i] == 0) consumer_write_valid[i] = 1'b0; else wh[i]--;
        end
      end
      if (consumer_read_valid == '0 && consumer_write_valid == '0 &&
          consumer_read_ready == '0 && consumer_write_ready == '0 &&
          exp_q.size() == 0 && !cur_valid) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_completed_in_budget"}, 32'(done), 32'd1);
    if (!done) begin
      exp_q.delete();
      cur_valid = 1'b0;
      consumer_read_valid  = '0;
      consumer_write_valid = '0;
    end
    for (int i = 0; i < N; i++)
      check({tag, "_read_data_held"}, 32'(consumer_read_data[i]), 32'(last_rd[i]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_read_valid"}, 32'(mem_read_valid), 32'd0);
    check({tag, "_mem_write_valid"}, 32'(mem_write_valid), 32'd0);
    check({tag, "_mem_read_address"}, 32'(mem_read_address), 32'd0);
    check({tag, "_mem_write_address"}, 32'(mem_write_address), 32'd0);
    check({tag, "_mem_write_data"}, 32'(mem_write_data), 32'd0);
    check({tag, "_consumer_read_ready"}, 32'(consumer_read_ready), 32'd0);
    check({tag, "_consumer_write_ready"}, 32'(consumer_write_ready), 32'd0);
    check({tag, "_consumer_read_data"}, 32'(consumer_read_data), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int starts0;
    int cnt;
    logic [DW-1:0] v;
    reset = 1'b0;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    for (int a = 0; a < 256; a++) begin
      v = DW'($urandom);
      ref_mem[a]   = v;
      mem_store[a] = v;
    end
    for (int i = 0; i < N; i++) last_rd[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;

    // All four consumers read at once from pointer 0: served 0,1,2,3
    clear_batch();
    for (int i = 0; i < N; i++) begin
      b_rv[i] = 1'b1;
      b_ra[i] = AW'(8'h40 + i);
    end
    starts0 = n_rd_starts;
    run_batch("all_read");
    check("all_read_count", 32'(n_rd_starts - starts0), 32'd4);

    // Consumer 1 writes 0xAB to 0x20 while consumer 3 reads 0x21
    clear_batch();
    b_wv[1] = 1'b1; b_wa[1] = 8'h20; b_wd[1] = 8'hAB;
    b_rv[3] = 1'b1; b_ra[3] = 8'h21;
    run_batch("write_then_read");

    // Consumer 0 reads and writes together: read first, write on a later grant
    clear_batch();
    b_rv[0] = 1'b1; b_ra[0] = 8'h20;
    b_wv[0] = 1'b1; b_wa[0] = 8'h22; b_wd[0] = 8'h3C;
    run_batch("read_and_write");

    // Consumer 2 reads 0x10, memory answers 0x5A after a fixed delay
    ref_mem[8'h10]   = 8'h5A;
    mem_store[8'h10] = 8'h5A;
    clear_batch();
    b_rv[2] = 1'b1; b_ra[2] = 8'h10;
    fixed_lat = 3;
    starts0 = n_rd_starts;
    run_batch("single_read");
    check("single_read_count", 32'(n_rd_starts - starts0), 32'd1);
    check("single_read_value", 32'(consumer_read_data[2]), 32'h5A);
    fixed_lat = -1;

    // Owner drops read_valid right after its grant: ready shows for one cycle
    clear_batch();
    b_rv[1] = 1'b1; b_ra[1] = AW'($urandom_range(0, 15));
    fixed_lat = 3;
    model_batch();
    @(posedge clk);
    #1;
    drive_batch();
    for (int k = 0; k < 20 && !mem_read_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("early_drop_granted", 32'(mem_read_valid), 32'd1);
    consumer_read_valid[1] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (consumer_read_ready[1]) cnt++;
      else if (cnt > 0) break;
    end
    check("early_drop_ready_cycles", 32'(cnt), 32'd1);
    check("early_drop_served", 32'(exp_q.size() == 0 && !cur_valid), 32'd1);
    fixed_lat = -1;

    // Reset while a read is waiting on memory
    clear_batch();
    b_rv[2] = 1'b1; b_ra[2] = 8'h33;
    fixed_lat = 8;
    model_batch();
    @(posedge clk);
    #1;
    drive_batch();
    for (int k = 0; k < 20 && !mem_read_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("reset_test_granted", 32'(mem_read_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    cur_valid = 1'b0;
    model_rr  = 0;
    for (int i = 0; i < N; i++) last_rd[i] = '0;
    consumer_read_valid = '0;
    fixed_lat = -1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (consumer_read_ready != '0 || consumer_write_ready != '0 ||
          mem_read_valid || mem_write_valid) cnt++;
    end
    check("post_reset_quiet_cycles", 32'(cnt), 32'd0);
    clear_batch();
    b_rv[2] = 1'b1; b_ra[2] = 8'h33;
    run_batch("after_reset");

    // Random batches
    for (int t = 0; t < 40; t++) begin
      clear_batch();
      for (int i = 0; i < N; i++) begin
        b_rv[i] = 1'($urandom_range(0, 1));
        b_wv[i] = 1'($urandom_range(0, 1));
        b_ra[i] = AW'($urandom_range(0, 15));
        b_wa[i] = AW'($urandom_range(0, 15));
        b_wd[i] = DW'($urandom);
      end
      run_batch("random");
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit for the whole run
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, expected the run to end earlier");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, the number of per-thread load-store requesters served (range 2..8).
REQ-002 SHALL have parameter ADDR_BITS, default 8, the data-memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, the data-memory word width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 SHALL have port consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request.
REQ-007 SHALL have port consumer_read_address  input  NUM_CONSUMERS x ADDR_BITS  per-consumer read address.
REQ-008 SHALL have port consumer_read_ready  output  NUM_CONSUMERS  per-consumer read completion.
REQ-009 SHALL have port consumer_read_data  output  NUM_CONSUMERS x DATA_BITS  per-consumer returned word.
REQ-010 SHALL have port consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request.
REQ-011 SHALL have port consumer_write_address  input  NUM_CONSUMERS x ADDR_BITS  per-consumer write address.
REQ-012 SHALL have port consumer_write_data  input  NUM_CONSUMERS x DATA_BITS  per-consumer write word.
REQ-013 SHALL have port consumer_write_ready  output  NUM_CONSUMERS  per-consumer write completion.
REQ-014 SHALL have ports mem_read_valid (output, 1), mem_read_address (output, ADDR_BITS), mem_read_ready (input, 1), mem_read_data (input, DATA_BITS): the single memory read channel.
REQ-015 SHALL have ports mem_write_valid (output, 1), mem_write_address (output, ADDR_BITS), mem_write_data (output, DATA_BITS), mem_write_ready (input, 1): the single memory write channel.

Function
REQ-016 SHALL use five states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
REQ-017 SHALL register every output; no combinational path from any input to any output.
REQ-018 SHALL, in IDLE, scan consumers starting at rr_ptr and wrapping modulo NUM_CONSUMERS, and grant the first one with read_valid or write_valid set.
REQ-019 SHALL give read priority over write when a granted consumer asserts both.
REQ-020 SHALL, on a read grant, latch the owner index, drive mem_read_valid=1 with the owner's address, and enter READ_WAITING.
REQ-021 SHALL, on a write grant, latch the owner index, drive mem_write_valid=1 with the owner's address and data, and enter WRITE_WAITING.
REQ-022 SHALL hold the memory address and data stable while the corresponding valid is high.
REQ-023 SHALL, in READ_WAITING with mem_read_ready=1, clear mem_read_valid, set consumer_read_ready[owner]=1, load consumer_read_data[owner] with mem_read_data, and enter READ_RELAYING.
REQ-024 SHALL, in WRITE_WAITING with mem_write_ready=1, clear mem_write_valid, set consumer_write_ready[owner]=1, and enter WRITE_RELAYING.
REQ-025 SHALL, in a RELAYING state, keep the owner's ready high until the owner's matching valid reads 0, then clear ready, set rr_ptr to (owner+1) mod NUM_CONSUMERS, and return to IDLE.
REQ-026 SHALL not abort a granted request if the owner drops valid early; the transfer completes and ready is shown for at least one cycle.
REQ-027 SHALL hold consumer_read_data[i] until the next read completion for consumer i.
REQ-028 SHALL ignore all non-owner requests from grant until return to IDLE; a pending request stays pending with no loss.
REQ-029 SHALL have a minimum turnaround of 4 edges per transfer: grant, memory ready, valid-drop observed, IDLE re-grant.

Reset
REQ-030 SHALL, while reset=0, drive every ready, every valid, every address, all data outputs and rr_ptr to 0, and force state IDLE, asynchronously.
REQ-031 SHALL discard any in-flight transfer on reset with no ready pulse afterwards; the first edge after release may grant.

Verification
REQ-032 SHALL pass: consumer 2 reads 0x10, memory returns 0x5A after 3 cycles -> one mem_read_valid at 0x10; consumer_read_ready[2]=1 and data[2]=0x5A until read_valid[2] drops.
REQ-033 SHALL pass: consumers 0..3 read simultaneously with rr_ptr=0 -> served in order 0,1,2,3, each exactly once; then rr_ptr=0.
REQ-034 SHALL pass: consumer 1 writes 0xAB to 0x20 while consumer 3 reads 0x21 -> write to 0x20 first, then read 0x21; no overlap of mem valids.
REQ-035 SHALL pass: consumer 0 asserts read and write together -> read served first, write served on a later grant.
REQ-036 SHALL pass: reset=0 during READ_WAITING -> all outputs 0 immediately, no ready pulse after release; a re-asserted request is then granted normally.
REQ-037 SHALL pass: owner drops read_valid during READ_WAITING -> completes, ready high exactly one cycle, then IDLE.
